flo_dispatcher: RTL and testbench
=================================

Name: flo_dispatcher

Overview:
- Producer end of the flobuffer write interface.
- Fetches 32-bit instruction words from a 1-cycle-latency BRAM and decodes them into flobuffer writes: shared data/delay bus plus per-buffer valid/direct strobes.
- Applies per-buffer flow control using each flobuffer's full flag.
- Sits between the host-loaded instruction memory and the bank of flobuffers that drive the output channels.

Parameters:
- num_buffers, 16, number of flobuffers driven; max 32.
- addr_width, 10, instruction memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle pulse; starts execution at address 0; ignored unless in IDLE or HALTED.
- mem_addr_o  out  addr_width  instruction memory read address.
- mem_en_o  out  1  memory read enable; data valid one cycle later.
- mem_data_i  in  32  instruction word.
- data_o  out  16  shared write data to all flobuffers.
- delay_o  out  7  shared delay field.
- valid_o  out  num_buffers  one-hot FIFO write strobe.
- direct_o  out  num_buffers  one-hot direct-write strobe.
- full_i  in  num_buffers  flobuffer full flags.
- running_o  out  1  high in FETCH/RUN/WAIT.
- halted_o  out  1  high in HALTED.
- err_o  out  1  sticky; set on bad buffer index or opcode; cleared by start_i or rst.

Behaviour:
- Instruction format:
  - [31:29] opcode: 0 NOP, 1 WRITE, 2 WAIT, 3 HALT, 4-7 illegal.
  - WRITE: [28:24] buffer index, [23] direct, [22:16] delay, [15:0] data.
  - WAIT: [15:0] cycle count N.
- Reset values: all outputs 0; state IDLE; PC 0; skid register empty.
- States and transitions:
  - IDLE --start_i--> FETCH.
  - FETCH: issues read of address 0, then enters RUN next cycle.
  - RUN: decodes one word per cycle; PC increments each cycle the pipeline is not stalled.
  - RUN --WAIT opcode--> WAIT. WAIT holds for exactly N cycles (N=0 behaves as NOP), then returns to RUN.
  - RUN --HALT opcode--> HALTED. HALTED --start_i--> FETCH.
- Throughput and latency:
  - One instruction per clock when no stall.
  - start_i at cycle t → mem_en_o at t+1 → first valid_o/direct_o at t+3 at the earliest.
  - All outputs are registered.
- WRITE issue:
  - Outputs data_o and delay_o.
  - Asserts valid_o[idx] if direct=0, direct_o[idx] if direct=1, for exactly one cycle.
  - direct=1 is issued regardless of full_i.
- Stall:
  - Occurs when a non-direct WRITE targets a buffer with full_i[idx]=1.
  - The word is held; mem_en_o deasserts; the in-flight fetched word is captured in a 1-entry skid register.
  - Issue occurs in the first cycle full_i[idx]=0.
- full_i contract: the flobuffer asserts full with one-entry margin. Back-to-back writes to the same buffer are therefore legal whenever full_i is low.
- Errors:
  - idx ≥ num_buffers or an illegal opcode: set err_o and treat the word as NOP. Execution continues.
- PC wrap: at 2^addr_width-1 the PC wraps to 0 without error.
- Simultaneous events:
  - start_i while running is ignored.
  - rst mid-operation aborts immediately; no partial strobe is emitted.
  - Outstanding WAIT counts are discarded.
- HALT while a stall is pending on an earlier word: the stalled WRITE completes before HALTED is entered.

Optional Feature:
- Macro: FLO_DISPATCH_STALL_COUNT_EN.
- When defined:
  - Adds output stall_cnt_o [31:0], counting cycles spent stalled on full_i.
  - Cleared on rst and start_i; saturates at 0xFFFFFFFF.
- When undefined: the port and counter are absent, with identical behaviour otherwise.

Decomposition:
- Shared package flo_pkg holds:
  - opcode constants OP_NOP/OP_WRITE/OP_WAIT/OP_HALT;
  - field bit positions;
  - the state encoding.
- One sub-module, flo_dispatch_skid: 1-entry skid register with valid flag, load/unload handshake.

Test Plan:
- Reset/idle: rst high 3 cycles, then low → all outputs 0, running_o=0, halted_o=0; no mem_en_o without start_i.
- Basic WRITE: mem[0]=WRITE idx3, delay 5, data 0x1234; mem[1]=HALT; start_i at t → valid_o=0x0008, data_o=0x1234, delay_o=5 at t+3 for one cycle; halted_o=1 at t+4.
- Stream plus flow control: 8 WRITEs to idx0 with data 1..8; hold full_i[0]=1 from the 3rd word for 4 cycles → words 1,2 issued back-to-back, 4-cycle gap, then 3..8 back-to-back in order, none lost or duplicated.
- WAIT and direct: WRITE idx1 direct data 0xBEEF, WAIT 10, WRITE idx2 data 7 with full_i[1]=1 → direct_o[1] pulses despite full; valid_o[2] exactly 11 cycles after direct_o.
- Error: WRITE idx 20 (num_buffers=16), opcode 6 → err_o set and sticky, no strobes; following HALT reached; next start_i clears err_o.
- Reset mid-stall, with FLO_DISPATCH_STALL_COUNT_EN defined: stall 5 cycles → stall_cnt_o=5; assert rst during a further stall → all outputs 0 in the same cycle, stall_cnt_o=0.

Source files
------------

// File: rtl/flo_pkg.sv
// Shared definitions for the flobuffer dispatcher: opcodes, instruction field
// positions, FSM state encoding and the instruction decode helper.
package flo_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_WAIT  = 3'd2;
  localparam logic [2:0] OP_HALT  = 3'd3;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 29;
  localparam int IDX_MSB    = 28;
  localparam int IDX_LSB    = 24;
  localparam int DIRECT_BIT = 23;
  localparam int DELAY_MSB  = 22;
  localparam int DELAY_LSB  = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  idx;
    logic        direct;
    logic [6:0]  delay;
    logic [15:0] data;   // WRITE payload, or cycle count for WAIT
  } flo_instr_t;

  function automatic flo_instr_t flo_decode(input logic [31:0] word);
    flo_instr_t d;
    d.op     = word[OP_MSB:OP_LSB];
    d.idx    = word[IDX_MSB:IDX_LSB];
    d.direct = word[DIRECT_BIT];
    d.delay  = word[DELAY_MSB:DELAY_LSB];
    d.data   = word[DATA_MSB:DATA_LSB];
    return d;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/flo_dispatch_skid.sv
// One-entry skid register: catches the instruction word that was already in
// flight from memory when the dispatcher stopped consuming words.
module flo_dispatch_skid #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             unload,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out,
  output logic             valid
);

  logic [width-1:0] data_reg;
  logic             valid_reg;

  // A load in the same cycle as an unload replaces the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= data_in;
      valid_reg <= 1'b1;
    end else if (unload) begin
      valid_reg <= 1'b0;
    end
  end

  assign data_out = data_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/flo_dispatcher.sv
// Fetches instruction words from a 1-cycle BRAM and turns them into flobuffer
// writes with per-buffer flow control. FLO_DISPATCH_STALL_COUNT_EN adds stall_cnt_o.
module flo_dispatcher
  import flo_pkg::*;
#(
  parameter int num_buffers = 16,
  parameter int addr_width  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic [addr_width-1:0]  mem_addr_o,
  output logic                   mem_en_o,
  input  logic [31:0]            mem_data_i,
  output logic [15:0]            data_o,
  output logic [6:0]             delay_o,
  output logic [num_buffers-1:0] valid_o,
  output logic [num_buffers-1:0] direct_o,
  input  logic [num_buffers-1:0] full_i,
  output logic                   running_o,
  output logic                   halted_o,
  output logic                   err_o
`ifdef FLO_DISPATCH_STALL_COUNT_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  logic [2:0]             state_reg, state_next;
  logic [addr_width-1:0]  pc_reg;
  logic                   mem_en_reg, mem_en_next;
  logic                   rd_pending_reg;
  logic [31:0]            hold_reg;
  logic                   hold_valid_reg;
  logic [15:0]            wait_cnt_reg, wait_next;
  logic [15:0]            data_reg;
  logic [6:0]             delay_reg;
  logic [num_buffers-1:0] valid_reg, direct_reg;
  logic                   running_reg, halted_reg, err_reg;

  logic                   skid_valid, skid_load, skid_unload;
  logic [31:0]            skid_data;
  logic [31:0]            cur_word;
  flo_instr_t             cur;
  logic                   start_ok, in_run, cur_valid, idx_ok;
  logic                   op_write, stall_now, issue, bad;
  logic [num_buffers-1:0] sel_hit, valid_next, direct_next;

  assign start_ok = start_i && (state_reg == ST_IDLE || state_reg == ST_HALTED);
  assign in_run   = (state_reg == ST_RUN);

  // Oldest word first: a stalled word, then the skid entry, then fresh memory data.
  assign cur_word  = hold_valid_reg ? hold_reg : (skid_valid ? skid_data : mem_data_i);
  assign cur_valid = in_run && (hold_valid_reg || skid_valid || rd_pending_reg);
  assign cur       = flo_decode(cur_word);
  assign idx_ok    = ({27'd0, cur.idx} < 32'(num_buffers));

  for (genvar gi = 0; gi < num_buffers; gi++) begin : g_buf
    assign sel_hit[gi]     = (cur.idx == 5'(gi));
    assign valid_next[gi]  = issue && !cur.direct && sel_hit[gi];
    assign direct_next[gi] = issue && cur.direct && sel_hit[gi];
  end

  assign op_write  = cur_valid && (cur.op == OP_WRITE) && idx_ok;
  assign stall_now = op_write && !cur.direct && |(sel_hit & full_i);
  assign issue     = op_write && !stall_now;
  assign bad       = cur_valid && (!op_legal(cur.op) || (cur.op == OP_WRITE && !idx_ok));

  // Words arriving while something older occupies decode (or during WAIT) are parked.
  assign skid_load   = rd_pending_reg &&
                       ((in_run && (hold_valid_reg || skid_valid)) || state_reg == ST_WAIT);
  assign skid_unload = in_run && !hold_valid_reg && skid_valid;

  flo_dispatch_skid #(.width(32)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (start_ok),
    .load     (skid_load),
    .unload   (skid_unload),
    .data_in  (mem_data_i),
    .data_out (skid_data),
    .valid    (skid_valid)
  );

  // A WAIT occupies max(N,1) cycles including its own decode cycle.
  always_comb begin
    state_next  = state_reg;
    mem_en_next = 1'b0;
    wait_next   = wait_cnt_reg;
    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (start_ok) begin
          state_next  = ST_FETCH;
          mem_en_next = 1'b1;
        end
      end
      ST_FETCH: begin
        state_next  = ST_RUN;
        mem_en_next = 1'b1;
      end
      ST_RUN: begin
        mem_en_next = !stall_now;
        if (cur_valid && cur.op == OP_WAIT && cur.data > 16'd1) begin
          state_next  = ST_WAIT;
          wait_next   = cur.data - 16'd1;
          mem_en_next = 1'b0;
        end else if (cur_valid && cur.op == OP_HALT) begin
          state_next  = ST_HALTED;
          mem_en_next = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg <= 16'd1) begin
          state_next  = ST_RUN;
          mem_en_next = 1'b1;
        end else begin
          wait_next = wait_cnt_reg - 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= '0;
      mem_en_reg     <= 1'b0;
      rd_pending_reg <= 1'b0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      wait_cnt_reg   <= '0;
      data_reg       <= '0;
      delay_reg      <= '0;
      valid_reg      <= '0;
      direct_reg     <= '0;
      running_reg    <= 1'b0;
      halted_reg     <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mem_en_reg     <= mem_en_next;
      rd_pending_reg <= mem_en_reg;
      pc_reg         <= start_ok ? '0 : (mem_en_reg ? pc_reg + 1'b1 : pc_reg);
      wait_cnt_reg   <= wait_next;
      hold_valid_reg <= stall_now;
      if (stall_now) hold_reg <= cur_word;
      valid_reg      <= valid_next;
      direct_reg     <= direct_next;
      if (issue) begin
        data_reg  <= cur.data;
        delay_reg <= cur.delay;
      end
      running_reg <= (state_next == ST_FETCH) || (state_next == ST_RUN) || (state_next == ST_WAIT);
      halted_reg  <= (state_next == ST_HALTED);
      if (start_ok)  err_reg <= 1'b0;
      else if (bad)  err_reg <= 1'b1;
    end
  end

`ifdef FLO_DISPATCH_STALL_COUNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    stall_cnt_reg <= '0;
    else if (start_ok)                          stall_cnt_reg <= '0;
    else if (stall_now && stall_cnt_reg != '1)  stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

  assign mem_addr_o = pc_reg;
  assign mem_en_o   = mem_en_reg;
  assign data_o     = data_reg;
  assign delay_o    = delay_reg;
  assign valid_o    = valid_reg;
  assign direct_o   = direct_reg;
  assign running_o  = running_reg;
  assign halted_o   = halted_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_flo_dispatcher.sv
// Bench for flo_dispatcher: directed timing scenarios, then random programs
// checked against an in-order list of expected buffer writes.
module tb_flo_dispatcher;

  localparam int NB = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_en_o;
  logic [31:0]   mem_data;
  logic [15:0]   data_o;
  logic [6:0]    delay_o;
  logic [NB-1:0] valid_o, direct_o, full_i;
  logic          running_o, halted_o, err_o;
`ifdef FLO_DISPATCH_STALL_COUNT_EN
  logic [31:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  flo_dispatcher #(.num_buffers(NB), .addr_width(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .mem_addr_o (mem_addr_o),
    .mem_en_o   (mem_en_o),
    .mem_data_i (mem_data),
    .data_o     (data_o),
    .delay_o    (delay_o),
    .valid_o    (valid_o),
    .direct_o   (direct_o),
    .full_i     (full_i),
    .running_o  (running_o),
    .halted_o   (halted_o),
    .err_o      (err_o)
`ifdef FLO_DISPATCH_STALL_COUNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en_o) mem_data <= mem[mem_addr_o];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
  endtask

  function automatic logic [31:0] w_write(input int idx, input bit dir, input int dly, input int dat);
    return {3'd1, 5'(idx), dir, 7'(dly), 16'(dat)};
  endfunction

  function automatic logic [31:0] w_wait(input int n);
    return {3'd2, 13'd0, 16'(n)};
  endfunction

  function automatic logic [31:0] w_halt();
    return {3'd3, 29'd0};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},   64'(mem_addr_o), 0);
    check({tag, "_en"},     64'(mem_en_o), 0);
    check({tag, "_data"},   64'(data_o), 0);
    check({tag, "_delay"},  64'(delay_o), 0);
    check({tag, "_valid"},  64'(valid_o), 0);
    check({tag, "_direct"}, 64'(direct_o), 0);
    check({tag, "_run"},    64'(running_o), 0);
    check({tag, "_halt"},   64'(halted_o), 0);
    check({tag, "_err"},    64'(err_o), 0);
  endtask

  initial begin
    int obs_cyc[$];
    int obs_dat[$];
    int exp_cyc[8] = '{3, 4, 9, 10, 11, 12, 13, 14};
    int dir_cyc, val_cyc, strobes;
    logic [63:0] exp_q[$];
    bit exp_err;

    rst = 1'b1; start_i = 1'b0; full_i = '0; mem_data = '0;
    mem_clear();

    // reset / idle
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");
    strobes = 0;
    repeat (4) begin tick(); if (mem_en_o) strobes++; end
    check("idle_no_fetch", strobes, 0);

    // basic write then halt
    mem[0] = w_write(3, 0, 5, 16'h1234);
    mem[1] = w_halt();
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("basic_en_t1", mem_en_o, 1);
    check("basic_addr_t1", mem_addr_o, 0);
    check("basic_run_t1", running_o, 1);
    tick();
    check("basic_valid_t2", valid_o, 0);
    tick();
    check("basic_valid_t3", valid_o, 16'h0008);
    check("basic_data_t3", data_o, 16'h1234);
    check("basic_delay_t3", delay_o, 5);
    $display("write buf=3 data=%h delay=%0d", data_o, delay_o);
    tick();
    check("basic_valid_t4", valid_o, 0);
    check("basic_halted_t4", halted_o, 1);
    check("basic_running_t4", running_o, 0);

    // stream with flow control on buffer 0
    mem_clear();
    for (int k = 0; k < 8; k++) mem[k] = w_write(0, 0, 0, k + 1);
    mem[8] = w_halt();
    start_i = 1'b1;
    for (int off = 1; off <= 20; off++) begin
      tick();
      start_i = 1'b0;
      full_i[0] = (off >= 4 && off <= 7);
      if (valid_o[0]) begin
        obs_cyc.push_back(off);
        obs_dat.push_back(int'(data_o));
        $display("write buf=0 data=%0d cycle=+%0d", data_o, off);
      end
    end
    check("stream_count", obs_cyc.size(), 8);
    for (int k = 0; k < 8 && k < obs_cyc.size(); k++) begin
      check($sformatf("stream_cyc%0d", k + 1), obs_cyc[k], exp_cyc[k]);
      check($sformatf("stream_dat%0d", k + 1), obs_dat[k], k + 1);
    end
    check("stream_halted", halted_o, 1);
`ifdef FLO_DISPATCH_STALL_COUNT_EN
    check("stream_stall_cnt", stall_cnt, 4);
`endif

    // direct write ignores full, WAIT spacing, start ignored while running
    mem_clear();
    mem[0] = w_write(1, 1, 0, 16'hBEEF);
    mem[1] = w_wait(10);
    mem[2] = w_write(2, 0, 3, 7);
    mem[3] = w_halt();
    full_i = 16'h0002;
    dir_cyc = -100; val_cyc = -100; strobes = 0;
    start_i = 1'b1;
    for (int off = 1; off <= 20; off++) begin
      tick();
      start_i = (off == 6);
      if (valid_o != 0 || direct_o != 0) strobes++;
      if (direct_o == 16'h0002) begin
        dir_cyc = off;
        check("wait_direct_data", data_o, 16'hBEEF);
        $display("direct buf=1 data=%h cycle=+%0d", data_o, off);
      end
      if (valid_o == 16'h0004) begin
        val_cyc = off;
        check("wait_write_data", data_o, 7);
        $display("write buf=2 data=%0d cycle=+%0d", data_o, off);
      end
    end
    start_i = 1'b0;
    full_i = '0;
    check("wait_strobes", strobes, 2);
    check("wait_direct_cyc", dir_cyc, 3);
    check("wait_gap", val_cyc - dir_cyc, 11);
    check("wait_halted", halted_o, 1);

    // errors: bad index, illegal opcode
    mem_clear();
    mem[0] = w_write(20, 0, 0, 16'h5555);
    mem[1] = {3'd6, 29'h0ABCDE};
    mem[2] = w_halt();
    strobes = 0;
    start_i = 1'b1;
    for (int off = 1; off <= 8; off++) begin
      tick();
      start_i = 1'b0;
      if (valid_o != 0 || direct_o != 0) strobes++;
      if (off == 2) check("err_before", err_o, 0);
      if (off == 3) check("err_set", err_o, 1);
    end
    check("err_no_strobes", strobes, 0);
    check("err_halted", halted_o, 1);
    check("err_sticky", err_o, 1);
    $display("error program halted err=%0d", err_o);
    mem[0] = w_halt();
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("err_cleared", err_o, 0);
    tick(); tick();
    check("err_restart_halted", halted_o, 1);
    check("err_stays_clear", err_o, 0);

    // reset in the middle of a stall
    mem_clear();
    mem[0] = w_write(5, 0, 1, 16'hAAAA);
    mem[1] = w_write(5, 0, 1, 16'hBBBB);
    mem[2] = w_halt();
    full_i = 16'h0020;
    strobes = 0;
    start_i = 1'b1;
    for (int off = 1; off <= 7; off++) begin
      tick();
      start_i = 1'b0;
      if (valid_o != 0 || direct_o != 0) strobes++;
    end
    check("rst_stall_no_issue", strobes, 0);
    check("rst_stall_running", running_o, 1);
`ifdef FLO_DISPATCH_STALL_COUNT_EN
    check("rst_stall_cnt5", stall_cnt, 5);
`endif
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
`ifdef FLO_DISPATCH_STALL_COUNT_EN
    check("rst_stall_cnt0", stall_cnt, 0);
`endif
    repeat (2) tick();
    rst = 1'b0;
    full_i = '0;
    tick();
    $display("reset during stall done");

    // random programs against an in-order write list
    for (int p = 0; p < 4; p++) begin
      int len, done;
      mem_clear();
      exp_q.delete();
      exp_err = 0;
      len = $urandom_range(40, 20);
      for (int i = 0; i < len; i++) begin
        int r, idx, dly, dat;
        bit dir;
        r   = $urandom_range(99, 0);
        idx = $urandom_range(NB - 1, 0);
        dir = ($urandom_range(3, 0) == 0);
        dly = $urandom_range(127, 0);
        dat = $urandom_range(65535, 0);
        if (r < 55) begin
          mem[i] = w_write(idx, dir, dly, dat);
          exp_q.push_back(64'({dir, 5'(idx), 7'(dly), 16'(dat)}));
        end else if (r < 63) begin
          mem[i] = w_write($urandom_range(31, NB), dir, dly, dat);
          exp_err = 1;
        end else if (r < 70) begin
          mem[i] = {3'($urandom_range(7, 4)), 29'($urandom)};
          exp_err = 1;
        end else if (r < 85) begin
          mem[i] = {3'd0, 29'($urandom)};
        end else begin
          mem[i] = {3'd2, 13'($urandom), 16'($urandom_range(4, 0))};
        end
      end
      mem[len] = w_halt();
      $display("program %0d: %0d words, %0d writes expected", p, len, exp_q.size());
      start_i = 1'b1;
      done = 0;
      for (int c = 0; c < 3000 && done == 0; c++) begin
        tick();
        start_i = 1'b0;
        if (valid_o != 0 || direct_o != 0) begin
          int idx;
          bit dir;
          logic [63:0] got;
          idx = 0;
          for (int i = 0; i < NB; i++) if (valid_o[i] || direct_o[i]) idx = i;
          dir = (direct_o != 0);
          check("rnd_onehot", $countones(valid_o) + $countones(direct_o), 1);
          got = 64'({dir, 5'(idx), delay_o, data_o});
          $display("write buf=%0d direct=%0d data=%h delay=%0d", idx, dir, data_o, delay_o);
          if (exp_q.size() == 0) begin
            check("rnd_extra_write", got, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("rnd_write", got, exp_q.pop_front());
          end
          if (!dir) check("rnd_full_respected", full_i[idx], 0);
        end
        if (halted_o) done = 1;
        full_i = NB'($urandom & $urandom);
      end
      full_i = '0;
      check("rnd_halt_reached", done, 1);
      check("rnd_writes_left", exp_q.size(), 0);
      check("rnd_err", err_o, exp_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
